// File: rtl/functions_pkg.sv
// -----------------------------------------------------------------------------
// functions_pkg
// Purpose : shared elaboration-time helper functions.
// Contents: clog2(value) - ceiling log2, returns 0 for value <= 1.
// -----------------------------------------------------------------------------
package functions_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Purpose : limits, derived widths, layer config record, controller state
//           encoding and small combinational helpers for the max-pool
//           layer controller.
// -----------------------------------------------------------------------------
package pool_pkg;
  import functions_pkg::*;

  localparam int FRAME_H_MAX = 224;
  localparam int FRAME_W_MAX = 224;
  localparam int STRIDE_MAX  = 4;
  localparam int WIN_SIZE    = 3;
  localparam int LAYER_NUM   = 8;

  localparam int LID_W  = clog2(LAYER_NUM - 1) + 1;
  localparam int H_W    = clog2(FRAME_H_MAX) + 1;
  localparam int W_W    = clog2(FRAME_W_MAX) + 1;
  localparam int S_W    = clog2(STRIDE_MAX) + 1;
  localparam int IND_W  = clog2(WIN_SIZE / 2) + 1;
  localparam int TBL_AW = clog2(LAYER_NUM);
  localparam int DIM_W  = (H_W > W_W) ? H_W : W_W;
  // One extra bit so padded sizes never wrap.
  localparam int NUM_W  = DIM_W + 1;
  localparam int CNT_W  = 16;
  localparam int WDOG_W = 16;

  localparam logic [LID_W-1:0] LAYER_NUM_L = LID_W'(LAYER_NUM);

  typedef struct packed {
    logic [H_W-1:0]   h;
    logic [W_W-1:0]   w;
    logic [S_W-1:0]   stride;
    logic [IND_W-1:0] indent;
  } layer_cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CALC_H = 3'd2,
    ST_CALC_W = 3'd3,
    ST_MUL    = 3'd4,
    ST_STREAM = 3'd5,
    ST_DRAIN  = 3'd6,
    ST_NEXT   = 3'd7
  } pool_state_e;

  // True when the entry cannot produce a legal pooled frame.
  function automatic logic cfg_invalid(input layer_cfg_t c);
    logic [NUM_W-1:0] ph;
    logic [NUM_W-1:0] pw;
    ph = NUM_W'(c.h) + (NUM_W'(c.indent) << 1);
    pw = NUM_W'(c.w) + (NUM_W'(c.indent) << 1);
    return (c.stride == '0) || (c.stride > S_W'(STRIDE_MAX)) ||
           (ph < NUM_W'(WIN_SIZE)) || (pw < NUM_W'(WIN_SIZE));
  endfunction

  // Padded length minus window: the dividend of the output-size division.
  function automatic logic [NUM_W-1:0] dim_num(input logic [DIM_W-1:0] len,
                                               input logic [IND_W-1:0] ind);
    return NUM_W'(len) + (NUM_W'(ind) << 1) - NUM_W'(WIN_SIZE);
  endfunction

endpackage

// File: rtl/pool_dim_calc.sv
// -----------------------------------------------------------------------------
// pool_dim_calc
// Purpose : sequential subtract divider, dim_o = floor(num_i / div_i) + 1.
//           One subtraction per cycle; reused for height then width.
// Ports   : clk, reset_n (sync, active low)
//           start_i  - pulse, captures num_i
//           num_i    - dividend (padded length minus window)
//           div_i    - divisor (stride), held stable while running
//           done_o   - one-cycle pulse when dim_o is valid
//           dim_o    - result, held until the next done
// -----------------------------------------------------------------------------
module pool_dim_calc
  import pool_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [S_W-1:0]   div_i,
  output logic             done_o,
  output logic [DIM_W-1:0] dim_o
);

  logic [NUM_W-1:0] rem_q;
  logic [DIM_W-1:0] cnt_q;
  logic [DIM_W-1:0] dim_q;
  logic             run_q;
  logic             done_q;

  // Divider: subtract while remainder covers the divisor, counting from 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q  <= '0;
      cnt_q  <= '0;
      dim_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q <= num_i;
        cnt_q <= DIM_W'(1);
        run_q <= 1'b1;
      end else if (run_q) begin
        // A zero divisor terminates immediately instead of spinning forever.
        if ((div_i != '0) && (rem_q >= NUM_W'(div_i))) begin
          rem_q <= rem_q - NUM_W'(div_i);
          cnt_q <= cnt_q + DIM_W'(1);
        end else begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
          dim_q  <= cnt_q;
        end
      end
    end
  end

  assign done_o = done_q;
  assign dim_o  = dim_q;

endmodule

// File: rtl/pool_layer_ctrl.sv
// -----------------------------------------------------------------------------
// pool_layer_ctrl
// Purpose : sequences a job over a contiguous range of layers for the max-pool
//           datapath: loads a per-layer config, computes the pooled output
//           size, gates the pixel stream, and counts outputs to find the end
//           of each frame.
// Ports   : clk, reset_n (sync, active low)
//           cfg_we/cfg_addr/cfg_h/cfg_w/cfg_stride/cfg_indent - table write
//           job_start/job_first/job_last - start a job over an inclusive range
//           src_vld/src_rdy  - upstream pixel handshake
//           frame_h/frame_w/stride/indent - config held stable per layer
//           fin_start/din_vld - frame start and pixel valid to the datapath
//           dout_vld - datapath output valid
//           layer_id/layer_done/busy/err - status
// Options : POOL_LAYER_CTRL_WDOG_EN adds a 16-bit drain watchdog that ends a
//           layer with err when dout_vld stops arriving.
// -----------------------------------------------------------------------------
module pool_layer_ctrl
  import pool_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [LID_W-1:0] cfg_addr,
  input  logic [H_W-1:0]   cfg_h,
  input  logic [W_W-1:0]   cfg_w,
  input  logic [S_W-1:0]   cfg_stride,
  input  logic [IND_W-1:0] cfg_indent,
  input  logic             job_start,
  input  logic [LID_W-1:0] job_first,
  input  logic [LID_W-1:0] job_last,
  input  logic             src_vld,
  output logic             src_rdy,
  output logic [H_W-1:0]   frame_h,
  output logic [W_W-1:0]   frame_w,
  output logic [S_W-1:0]   stride,
  output logic [IND_W-1:0] indent,
  output logic             fin_start,
  output logic             din_vld,
  input  logic             dout_vld,
  output logic [LID_W-1:0] layer_id,
  output logic             layer_done,
  output logic             busy,
  output logic             err
);

  layer_cfg_t       tbl_q [LAYER_NUM];
  layer_cfg_t       ent_s;
  pool_state_e      state_q;
  logic [H_W-1:0]   frame_h_q;
  logic [W_W-1:0]   frame_w_q;
  logic [S_W-1:0]   stride_q;
  logic [IND_W-1:0] indent_q;
  logic [LID_W-1:0] layer_id_q;
  logic [LID_W-1:0] job_last_q;
  logic             src_rdy_q;
  logic             first_q;
  logic             layer_done_q;
  logic             busy_q;
  logic             err_q;
  logic             calc_start_q;
  logic             calc_sel_w_q;
  logic [DIM_W-1:0] out_h_q;
  logic [DIM_W-1:0] out_w_q;
  logic [CNT_W-1:0] in_cnt_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic [CNT_W-1:0] out_cnt_d;
  logic [CNT_W-1:0] total_q;
  logic [NUM_W-1:0] calc_num_s;
  logic [DIM_W-1:0] calc_dim_s;
  logic             calc_done_s;
  logic             accept_s;
  logic             out_ovf_s;
  logic             cfg_wr_ok_s;
`ifdef POOL_LAYER_CTRL_WDOG_EN
  logic [WDOG_W-1:0] wdog_q;
`endif

  // The entry of the running layer is frozen; out-of-range addresses drop.
  assign cfg_wr_ok_s = cfg_we && (cfg_addr < LAYER_NUM_L) &&
                       !(busy_q && (cfg_addr == layer_id_q));
  assign ent_s       = tbl_q[layer_id_q[TBL_AW-1:0]];
  assign accept_s    = src_vld & src_rdy_q;

  // Config table storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (cfg_wr_ok_s) begin
      tbl_q[cfg_addr[TBL_AW-1:0]] <= '{h: cfg_h, w: cfg_w, stride: cfg_stride, indent: cfg_indent};
    end
  end

  // Height is divided first, then width, through the one shared divider.
  assign calc_num_s = calc_sel_w_q ? dim_num(DIM_W'(frame_w_q), indent_q)
                                   : dim_num(DIM_W'(frame_h_q), indent_q);

  pool_dim_calc u_dim_calc (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (calc_start_q),
    .num_i   (calc_num_s),
    .div_i   (stride_q),
    .done_o  (calc_done_s),
    .dim_o   (calc_dim_s)
  );

  // Output counter: counts in STREAM/DRAIN, saturates at total and flags overflow.
  always_comb begin
    out_cnt_d = out_cnt_q;
    out_ovf_s = 1'b0;
    if (((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && dout_vld) begin
      if (out_cnt_q == total_q) begin
        out_ovf_s = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + CNT_W'(1);
      end
    end else begin
      out_cnt_d = out_cnt_q;
    end
  end

  // Layer sequencer FSM with registered status and datapath config.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      frame_h_q    <= '0;
      frame_w_q    <= '0;
      stride_q     <= '0;
      indent_q     <= '0;
      layer_id_q   <= '0;
      job_last_q   <= '0;
      src_rdy_q    <= 1'b0;
      first_q      <= 1'b0;
      layer_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      calc_start_q <= 1'b0;
      calc_sel_w_q <= 1'b0;
      out_h_q      <= '0;
      out_w_q      <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      total_q      <= '0;
`ifdef POOL_LAYER_CTRL_WDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      layer_done_q <= 1'b0;
      calc_start_q <= 1'b0;
      out_cnt_q    <= out_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (job_start) begin
            if (job_first <= job_last) begin
              state_q    <= ST_LOAD;
              busy_q     <= 1'b1;
              err_q      <= 1'b0;
              layer_id_q <= job_first;
              job_last_q <= job_last;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          frame_h_q <= ent_s.h;
          frame_w_q <= ent_s.w;
          stride_q  <= ent_s.stride;
          indent_q  <= ent_s.indent;
          out_cnt_q <= '0;
          if (cfg_invalid(ent_s)) begin
            err_q        <= 1'b1;
            layer_done_q <= 1'b1;
            state_q      <= ST_NEXT;
          end else begin
            calc_start_q <= 1'b1;
            calc_sel_w_q <= 1'b0;
            state_q      <= ST_CALC_H;
          end
        end
        ST_CALC_H: begin
          if (calc_done_s) begin
            out_h_q      <= calc_dim_s;
            calc_start_q <= 1'b1;
            calc_sel_w_q <= 1'b1;
            state_q      <= ST_CALC_W;
          end
        end
        ST_CALC_W: begin
          if (calc_done_s) begin
            out_w_q <= calc_dim_s;
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          total_q   <= CNT_W'(out_h_q) * CNT_W'(out_w_q);
          in_cnt_q  <= CNT_W'(frame_h_q) * CNT_W'(frame_w_q);
          first_q   <= 1'b1;
          src_rdy_q <= 1'b1;
          state_q   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (accept_s) begin
            first_q  <= 1'b0;
            in_cnt_q <= in_cnt_q - CNT_W'(1);
            if (in_cnt_q == CNT_W'(1)) begin
              src_rdy_q <= 1'b0;
              state_q   <= ST_DRAIN;
`ifdef POOL_LAYER_CTRL_WDOG_EN
              wdog_q    <= '1;
`endif
            end
          end
        end
        ST_DRAIN: begin
          if (out_cnt_q == total_q) begin
            layer_done_q <= 1'b1;
            state_q      <= ST_NEXT;
`ifdef POOL_LAYER_CTRL_WDOG_EN
          end else if (wdog_q == '0) begin
            err_q        <= 1'b1;
            layer_done_q <= 1'b1;
            state_q      <= ST_NEXT;
          end else if (dout_vld) begin
            wdog_q <= '1;
          end else begin
            wdog_q <= wdog_q - WDOG_W'(1);
`endif
          end
        end
        ST_NEXT: begin
          if (layer_id_q == job_last_q) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            layer_id_q <= layer_id_q + LID_W'(1);
            state_q    <= ST_LOAD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      if (out_ovf_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign src_rdy    = src_rdy_q;
  assign din_vld    = accept_s;
  assign fin_start  = accept_s & first_q;
  assign frame_h    = frame_h_q;
  assign frame_w    = frame_w_q;
  assign stride     = stride_q;
  assign indent     = indent_q;
  assign layer_id   = layer_id_q;
  assign layer_done = layer_done_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: doc/pool_layer_ctrl.md
Name: pool_layer_ctrl

Overview:
- Sequencer in front of the max-pool datapath (row buffer + window/pad + per-channel max cores).
- Holds a small table of per-layer pooling configs and runs a job over a contiguous range of layers.
- Per layer it drives a stable frame_h/frame_w/stride/indent, gates the upstream pixel stream into din_vld/fin_start, and counts dout_vld against the computed output size to detect frame completion.

Parameters:
- FRAME_H_MAX, 224, max input frame height.
- FRAME_W_MAX, 224, max input frame width.
- STRIDE_MAX, 4, max pooling stride.
- WIN_SIZE, 3, pooling window side (odd).
- LAYER_NUM, 8, config table depth.
- LID_W, clog2(LAYER_NUM-1)+1, layer index width (derived).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- cfg_we  in  1  write one table entry.
- cfg_addr  in  LID_W  entry index.
- cfg_h  in  clog2(FRAME_H_MAX)+1  frame height.
- cfg_w  in  clog2(FRAME_W_MAX)+1  frame width.
- cfg_stride  in  clog2(STRIDE_MAX)+1  stride.
- cfg_indent  in  clog2(WIN_SIZE/2)+1  pad indent.
- job_start  in  1  pulse: run layers job_first..job_last.
- job_first, job_last  in  LID_W  inclusive layer range.
- src_vld  in  1  upstream pixel valid.
- src_rdy  out  1  controller accepts pixel.
- frame_h, frame_w, stride, indent  out  cfg widths  datapath config.
- fin_start  out  1  to datapath, coincident with first din_vld of frame.
- din_vld  out  1  = src_vld & src_rdy.
- dout_vld  in  1  datapath output valid.
- layer_id  out  LID_W  current layer.
- layer_done  out  1  pulse per finished layer.
- busy  out  1  job in progress.
- err  out  1  sticky config error.

Behaviour:
- Reset: all outputs 0; state IDLE; table contents undefined.
- Config writes are accepted any cycle. A write to the active layer's entry while busy is ignored.
- FSM:
  - IDLE: job_start with job_first<=job_last → LOAD, busy=1, layer_id=job_first. job_first>job_last → err=1, stay IDLE.
  - LOAD (1 cycle): register the entry into frame_h/w/stride/indent; these stay constant until the next LOAD. Validity check: stride==0, stride>STRIDE_MAX, h+2*indent<WIN_SIZE or w+2*indent<WIN_SIZE → err=1, skip to NEXT with no stream.
  - CALC: compute out_h=floor((h+2*indent-WIN_SIZE)/stride)+1 by repeated subtraction, one subtraction per cycle; then out_w the same way; then total=out_h*out_w (registered multiply, 1 cycle). Load in_cnt=h*w. → STREAM.
  - STREAM: src_rdy=1. On each accept, decrement in_cnt. The first accept of the frame asserts fin_start the same cycle. When in_cnt hits 0 on an accept, src_rdy drops the next cycle → DRAIN.
  - DRAIN: src_rdy=0; wait until out_cnt==total.
  - out_cnt counts dout_vld in both STREAM and DRAIN. It clears in LOAD. It may reach total during STREAM; the layer still completes only after in_cnt==0.
  - NEXT: layer_done pulse. layer_id==job_last → IDLE, busy=0. Otherwise layer_id+1 → LOAD.
- job_start while busy is ignored.
- Extra dout_vld beyond total in DRAIN/STREAM: saturate out_cnt, set err.
- src_vld low in STREAM: pure stall, no count.
- err clears only on reset or on job_start accepted from IDLE.
- Reset mid-frame returns to IDLE next cycle. The datapath is reset by the same reset_n.

Optional Feature:
- POOL_LAYER_CTRL_WDOG_EN: adds a 16-bit drain watchdog. It reloads on each dout_vld in DRAIN; on expiry it sets err, pulses layer_done and goes to NEXT.
- Without the macro, DRAIN waits indefinitely.

Decomposition:
- Shared package (pool_pkg):
  - layer_cfg_t struct {h, w, stride, indent}.
  - state enum.
  - width constants derived via functions_pkg::clog2.
- One sub-module, pool_dim_calc: sequential subtract divider computing the output dimension, with start/done handshake. It is instantiated once and reused for height then width.

Test Plan:
- Layer0 h=w=8, stride=2, indent=1, WIN 3: job 0..0, src_vld constant → out 4x4.
  - 64 din_vld with fin_start on the first.
  - Drive 16 dout_vld → one layer_done, busy falls the next cycle.
- Layers 0..2 with different configs: config outputs change only in LOAD. layer_id steps 0,1,2; three layer_done pulses.
- stride=0 in layer 1 of a 0..2 job: err=1, layer 1 streams nothing, layer 2 runs normally.
- Random src_vld gaps in STREAM (h=w=5, stride=1, indent=0): exactly 25 accepts. src_rdy is 0 after the last accept.
- 17 dout_vld against total 16: err set. Reset mid-STREAM: all outputs 0 next cycle.
- With POOL_LAYER_CTRL_WDOG_EN, withhold dout_vld after 10 of 16: err and layer_done fire at expiry.
